// File: rtl/cci_mpf_read_stream_pkg.sv
// cci_mpf_read_stream_pkg: shared types for the MPF read-stream engine
package cci_mpf_read_stream_pkg;
   localparam int CL_BYTES = 64;
   localparam int CL_ADDR_WIDTH = 42;
   localparam int LINE_CNT_WIDTH = 32;
   typedef logic [CL_ADDR_WIDTH-1:0] t_cl_addr;
   typedef logic [LINE_CNT_WIDTH-1:0] t_line_count;
   typedef enum logic [1:0] {RS_IDLE, RS_RUN, RS_DRAIN, RS_DONE} t_rs_state;
endpackage

// File: rtl/cci_mpf_read_stream_fifo.sv
// cci_mpf_read_stream_fifo: first-word-fall-through FIFO over a synchronous-read RAM
module cci_mpf_read_stream_fifo #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 513
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wrData,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdData,
   output logic                       notEmpty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wrPtr, rdPtr, rdNext;
   logic doPop;
   assign notEmpty = (count != '0);
   assign doPop = pop && notEmpty;
   assign rdNext = rdPtr + AW'(doPop);
   always_ff @(posedge clk) begin
      if (push) mem[wrPtr] <= wrData;
   end
   // The head register pre-reads the next head; a push into that slot bypasses the RAM.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         rdData <= '0;
      end else begin
         wrPtr <= wrPtr + AW'(push);
         rdPtr <= rdNext;
         count <= count + CW'(push) - CW'(doPop);
         rdData <= (push && wrPtr == rdNext) ? wrData : mem[rdNext];
      end
   end
endmodule

// File: rtl/cci_mpf_read_stream.sv
// cci_mpf_read_stream: issues sequential c0 line reads and streams the data out in order
module cci_mpf_read_stream
   import cci_mpf_read_stream_pkg::*;
#(
   parameter int FIFO_DEPTH = 64,
   parameter int MAX_OUTSTANDING = 32,
   parameter int CNT_WIDTH = LINE_CNT_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  t_cl_addr                base_addr,
   input  logic [CNT_WIDTH-1:0]    num_lines,
   output logic                    busy,
   output logic                    done,
   output logic                    c0_req_valid,
   output t_cl_addr                c0_req_addr,
   output logic [15:0]             c0_req_mdata,
   input  logic                    c0_alm_full,
   input  logic                    c0_rsp_valid,
   input  logic [CL_BYTES*8-1:0]   c0_rsp_data,
   output logic                    out_valid,
   output logic [CL_BYTES*8-1:0]   out_data,
   output logic                    out_last,
   input  logic                    out_ready
);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int FCW = $clog2(FIFO_DEPTH + 1);
   t_rs_state state, nextState;
   t_cl_addr baseQ;
   logic [CNT_WIDTH-1:0] numQ, issued, received;
   logic [OW-1:0] outstanding;
   logic [FCW-1:0] fifoCount;
   logic [CL_BYTES*8:0] head;
   logic active, canIssue, rspAccept, pop, stickyErr;

   assign active = (state == RS_RUN) || (state == RS_DRAIN);
   // Every issued read holds a FIFO slot until its line is popped, so responses never stall.
   assign canIssue = (state == RS_RUN) && (issued != numQ) && !c0_alm_full
                     && (32'(outstanding) < MAX_OUTSTANDING)
                     && (32'(outstanding) + 32'(fifoCount) < FIFO_DEPTH);
   assign rspAccept = c0_rsp_valid && active && (outstanding != '0);
   assign pop = out_valid && out_ready;
   assign out_data = head[CL_BYTES*8-1:0];
   assign out_last = out_valid && head[CL_BYTES*8];

   always_comb begin
      nextState = state;
      busy = (state != RS_IDLE);
      done = (state == RS_DONE);
      case (state)
         RS_IDLE: nextState = !start ? RS_IDLE : (num_lines == '0) ? RS_DONE : RS_RUN;
         RS_RUN, RS_DRAIN: nextState = (pop && out_last) ? RS_DONE : (issued == numQ) ? RS_DRAIN : state;
         default: nextState = RS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RS_IDLE;
         baseQ <= '0;
         numQ <= '0;
         issued <= '0;
         received <= '0;
         outstanding <= '0;
         c0_req_valid <= 1'b0;
         c0_req_addr <= '0;
         c0_req_mdata <= '0;
         stickyErr <= 1'b0;
      end else begin
         state <= nextState;
         if (state == RS_IDLE && start) begin
            baseQ <= base_addr;
            numQ <= num_lines;
            issued <= '0;
            received <= '0;
         end
         if (canIssue) issued <= issued + CNT_WIDTH'(1);
         if (rspAccept) received <= received + CNT_WIDTH'(1);
         outstanding <= outstanding + OW'(canIssue) - OW'(rspAccept);
         c0_req_valid <= canIssue;
         c0_req_addr <= baseQ + t_cl_addr'(issued);
         c0_req_mdata <= issued[15:0];
         stickyErr <= stickyErr || (c0_rsp_valid && !rspAccept);
      end
   end

   cci_mpf_read_stream_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CL_BYTES*8+1)) fifo (
      .clk(clk),
      .reset(reset),
      .push(rspAccept),
      .wrData({received == numQ - CNT_WIDTH'(1), c0_rsp_data}),
      .pop(pop),
      .rdData(head),
      .notEmpty(out_valid),
      .count(fifoCount)
   );
endmodule

// File: tb/tb_cci_mpf_read_stream.sv
// tb_cci_mpf_read_stream: randomized scenarios against a queue-based model of the read stream
module tb_cci_mpf_read_stream;
   import cci_mpf_read_stream_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1, start = 1'b0, c0_alm_full = 1'b0, c0_rsp_valid = 1'b0, out_ready = 1'b1;
   t_cl_addr base_addr = '0;
   logic [31:0] num_lines = '0;
   logic busy, done, c0_req_valid, out_valid, out_last;
   t_cl_addr c0_req_addr;
   logic [15:0] c0_req_mdata;
   logic [511:0] c0_rsp_data = '0;
   logic [511:0] out_data;
   int vectors = 0, miscompares = 0, cyc = 0, startCyc = 0, busyCycles = 0, stabErr = 0, readyMode = 0;
   bit rspEn = 1'b1, prevStall = 1'b0;
   logic [511:0] prevData = '0;
   t_cl_addr reqLog[$], pend[$];
   logic [15:0] reqTag[$];
   logic [511:0] gotData[$];
   logic gotLast[$];
   int gotCyc[$], doneCyc[$];

   cci_mpf_read_stream dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_lines(num_lines),
      .busy(busy), .done(done), .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr),
      .c0_req_mdata(c0_req_mdata), .c0_alm_full(c0_alm_full), .c0_rsp_valid(c0_rsp_valid),
      .c0_rsp_data(c0_rsp_data), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [511:0] lineData(t_cl_addr a);
      logic [511:0] d;
      for (int i = 0; i < 8; i++) d[i*64 +: 64] = {22'(i), a} ^ 64'h5A5A_0F0F_3C3C_9696;
      return d;
   endfunction

   // Memory model returns lines in request order after a random delay; consumer and logs live here.
   always @(negedge clk) begin
      if (rspEn && pend.size() > 0 && $urandom_range(0, 3) != 0) begin
         c0_rsp_valid = 1'b1;
         c0_rsp_data = lineData(pend.pop_front());
      end else c0_rsp_valid = 1'b0;
      if (c0_req_valid) begin
         pend.push_back(c0_req_addr);
         reqLog.push_back(c0_req_addr);
         reqTag.push_back(c0_req_mdata);
      end
      out_ready = (readyMode == 0) ? 1'b1 : (readyMode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      if (prevStall && out_valid && out_data !== prevData) stabErr++;
      prevStall = out_valid && !out_ready;
      prevData = out_data;
      if (out_valid && out_ready) begin
         gotData.push_back(out_data);
         gotLast.push_back(out_last);
         gotCyc.push_back(cyc);
      end
      if (done) doneCyc.push_back(cyc);
      if (busy) busyCycles++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      reqLog.delete(); reqTag.delete(); gotData.delete(); gotLast.delete(); gotCyc.delete(); doneCyc.delete();
      busyCycles = 0;
   endtask

   task automatic start_job(input t_cl_addr b, input logic [31:0] n);
      tick(1);
      base_addr = b;
      num_lines = n;
      start = 1'b1;
      startCyc = cyc;
      tick(1);
      start = 1'b0;
      base_addr = t_cl_addr'({$urandom, $urandom});
      num_lines = $urandom;
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         tick(1);
         ok = (doneCyc.size() > 0);
      end
      tick(3);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(3);
      vectors++;
      if ({busy, done, c0_req_valid, out_valid, out_last} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: busy,done,req,valid,last = %b, expected 00000", {busy, done, c0_req_valid, out_valid, out_last});
      end
      reset = 1'b0;
      tick(4);
      vectors++;
      if ({busy, done, c0_req_valid, out_valid} !== 4'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset: busy,done,req,valid = %b, expected 0000", {busy, done, c0_req_valid, out_valid});
      end
   endtask

   task automatic test_basic();
      t_cl_addr b = 42'h1000;
      bit ok;
      clear_logs();
      readyMode = 0;
      start_job(b, 8);
      wait_done(500, ok);
      vectors++;
      if (!ok || reqLog.size() != 8 || gotData.size() != 8) begin
         miscompares++;
         $display("FAIL basic_counts: done %b reqs %0d lines %0d, expected 1 8 8", ok, reqLog.size(), gotData.size());
      end
      for (int i = 0; i < 8 && i < reqLog.size(); i++) begin
         vectors++;
         if (reqLog[i] !== b + 42'(i) || reqTag[i] !== 16'(i)) begin
            miscompares++;
            $display("FAIL basic_req %0d: addr %h tag %h, expected %h %h", i, reqLog[i], reqTag[i], b + 42'(i), 16'(i));
         end
      end
      for (int i = 0; i < 8 && i < gotData.size(); i++) begin
         vectors++;
         if (gotData[i] !== lineData(b + 42'(i)) || gotLast[i] !== (i == 7)) begin
            miscompares++;
            $display("FAIL basic_line %0d: last %b data %h, expected last %b data %h", i, gotLast[i], gotData[i], i == 7, lineData(b + 42'(i)));
         end
      end
      vectors++;
      if (gotCyc.size() != 8 || doneCyc.size() != 1 || doneCyc[0] != gotCyc[7] + 1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_done: pulses %0d at %0d busy %b, expected 1 pulse one cycle after last line, busy 0",
                  doneCyc.size(), doneCyc.size() > 0 ? doneCyc[0] : -1, busy);
      end
   endtask

   task automatic test_zero_lines();
      clear_logs();
      start_job(42'h2000, 0);
      tick(6);
      vectors++;
      if (reqLog.size() != 0 || doneCyc.size() != 1 || busyCycles != 1) begin
         miscompares++;
         $display("FAIL zero_job: reqs %0d dones %0d busy cycles %0d, expected 0 1 1", reqLog.size(), doneCyc.size(), busyCycles);
      end
      vectors++;
      if (doneCyc.size() > 0 && doneCyc[0] != startCyc + 1) begin
         miscompares++;
         $display("FAIL zero_done_time: done at %0d, expected %0d", doneCyc[0], startCyc + 1);
      end
   endtask

   task automatic test_backpressure();
      t_cl_addr b = t_cl_addr'({$urandom, $urandom});
      bit ok;
      clear_logs();
      readyMode = 2;
      start_job(b, 200);
      tick(300);
      vectors++;
      if (reqLog.size() != 64 || gotData.size() != 0 || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_stall: reqs %0d lines %0d valid %b, expected 64 0 1", reqLog.size(), gotData.size(), out_valid);
      end
      readyMode = 1;
      wait_done(5000, ok);
      vectors++;
      if (!ok || reqLog.size() != 200 || gotData.size() != 200 || stabErr != 0) begin
         miscompares++;
         $display("FAIL bp_counts: done %b reqs %0d lines %0d unstable %0d, expected 1 200 200 0", ok, reqLog.size(), gotData.size(), stabErr);
      end
      for (int i = 0; i < 200 && i < gotData.size() && i < reqLog.size(); i++) begin
         vectors++;
         if (reqLog[i] !== b + 42'(i) || gotData[i] !== lineData(b + 42'(i)) || gotLast[i] !== (i == 199)) begin
            miscompares++;
            $display("FAIL bp_line %0d: addr %h last %b, expected addr %h last %b (data match %b)",
                     i, reqLog[i], gotLast[i], b + 42'(i), i == 199, gotData[i] === lineData(b + 42'(i)));
         end
      end
   endtask

   task automatic test_alm_full();
      t_cl_addr b = t_cl_addr'({$urandom, $urandom});
      bit ok;
      int n0;
      clear_logs();
      readyMode = 1;
      start_job(b, 100);
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         tick(1);
         ok = (reqLog.size() >= 20);
      end
      c0_alm_full = 1'b1;
      tick(2);
      n0 = reqLog.size();
      tick(48);
      vectors++;
      if (!ok || reqLog.size() != n0) begin
         miscompares++;
         $display("FAIL almfull_window: reqs before %0d after %0d, expected no growth", n0, reqLog.size());
      end
      c0_alm_full = 1'b0;
      wait_done(3000, ok);
      vectors++;
      if (!ok || reqLog.size() != 100 || gotData.size() != 100) begin
         miscompares++;
         $display("FAIL almfull_counts: done %b reqs %0d lines %0d, expected 1 100 100", ok, reqLog.size(), gotData.size());
      end
      for (int i = 0; i < 100 && i < gotData.size() && i < reqLog.size(); i++) begin
         vectors++;
         if (reqLog[i] !== b + 42'(i) || gotData[i] !== lineData(b + 42'(i)) || gotLast[i] !== (i == 99)) begin
            miscompares++;
            $display("FAIL almfull_line %0d: addr %h last %b, expected addr %h last %b", i, reqLog[i], gotLast[i], b + 42'(i), i == 99);
         end
      end
   endtask

   task automatic test_addr_wrap();
      t_cl_addr expA[4] = '{42'h3FF_FFFF_FFFE, 42'h3FF_FFFF_FFFF, 42'h0, 42'h1};
      bit ok;
      clear_logs();
      readyMode = 1;
      start_job(42'h3FF_FFFF_FFFE, 4);
      wait_done(500, ok);
      vectors++;
      if (!ok || reqLog.size() != 4 || gotData.size() != 4) begin
         miscompares++;
         $display("FAIL wrap_counts: done %b reqs %0d lines %0d, expected 1 4 4", ok, reqLog.size(), gotData.size());
      end
      for (int i = 0; i < 4 && i < reqLog.size() && i < gotData.size(); i++) begin
         vectors++;
         if (reqLog[i] !== expA[i] || gotData[i] !== lineData(expA[i]) || gotLast[i] !== (i == 3)) begin
            miscompares++;
            $display("FAIL wrap_line %0d: addr %h last %b, expected addr %h last %b", i, reqLog[i], gotLast[i], expA[i], i == 3);
         end
      end
   endtask

   task automatic test_reset_mid_job();
      t_cl_addr b = t_cl_addr'({$urandom, $urandom});
      bit ok;
      clear_logs();
      rspEn = 1'b0;
      readyMode = 2;
      start_job(b, 100);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         tick(1);
         ok = (reqLog.size() >= 10);
      end
      reset = 1'b1;
      tick(1);
      vectors++;
      if (!ok || {busy, done, c0_req_valid, out_valid, out_last} !== 5'b0) begin
         miscompares++;
         $display("FAIL midreset_outputs: reqs seen %0d busy,done,req,valid,last = %b, expected >=10 and 00000",
                  reqLog.size(), {busy, done, c0_req_valid, out_valid, out_last});
      end
      reset = 1'b0;
      rspEn = 1'b1;
      readyMode = 0;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         tick(1);
         ok = (pend.size() == 0);
      end
      tick(5);
      vectors++;
      if (!ok || gotData.size() != 0 || out_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL late_rsp_discard: drained %b lines %0d valid %b busy %b, expected 1 0 0 0", ok, gotData.size(), out_valid, busy);
      end
      clear_logs();
      b = t_cl_addr'({$urandom, $urandom});
      start_job(b, 4);
      wait_done(500, ok);
      vectors++;
      if (!ok || reqLog.size() != 4 || gotData.size() != 4) begin
         miscompares++;
         $display("FAIL postreset_counts: done %b reqs %0d lines %0d, expected 1 4 4", ok, reqLog.size(), gotData.size());
      end
      for (int i = 0; i < 4 && i < reqLog.size() && i < gotData.size(); i++) begin
         vectors++;
         if (reqLog[i] !== b + 42'(i) || gotData[i] !== lineData(b + 42'(i)) || gotLast[i] !== (i == 3)) begin
            miscompares++;
            $display("FAIL postreset_line %0d: addr %h last %b, expected addr %h last %b", i, reqLog[i], gotLast[i], b + 42'(i), i == 3);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int j = 0; j < 4; j++) begin
         t_cl_addr b = t_cl_addr'({$urandom, $urandom});
         int n = $urandom_range(4, 60);
         bit ok;
         clear_logs();
         readyMode = 1;
         start_job(b, 32'(n));
         tick(2);
         start = 1'b1;
         tick(1);
         start = 1'b0;
         wait_done(3000, ok);
         vectors++;
         if (!ok || doneCyc.size() != 1 || reqLog.size() != n || gotData.size() != n || stabErr != 0) begin
            miscompares++;
            $display("FAIL b2b_counts job %0d: done %b pulses %0d reqs %0d lines %0d unstable %0d, expected 1 1 %0d %0d 0",
                     j, ok, doneCyc.size(), reqLog.size(), gotData.size(), stabErr, n, n);
         end
         for (int i = 0; i < n && i < reqLog.size() && i < gotData.size(); i++) begin
            vectors++;
            if (reqLog[i] !== b + 42'(i) || reqTag[i] !== 16'(i) || gotData[i] !== lineData(b + 42'(i)) || gotLast[i] !== (i == n - 1)) begin
               miscompares++;
               $display("FAIL b2b_line job %0d idx %0d: addr %h tag %h last %b, expected addr %h tag %h last %b",
                        j, i, reqLog[i], reqTag[i], gotLast[i], b + 42'(i), 16'(i), i == n - 1);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_lines();
      test_backpressure();
      test_alm_full();
      test_addr_wrap();
      test_reset_mid_job();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
